// File: rtl/phase_sequencer.sv
// Multi-phase timing sequencer: steps through NUM_PHASES phases of programmable
// length on start, then finishes in a sticky DONE level or wraps to phase 0.
module phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 8,
    parameter int LOOP       = 0,
    parameter int PH_W       = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [NUM_PHASES*CNT_W-1:0] dur,
    output logic [PH_W-1:0]             phase_idx,
    output logic [NUM_PHASES-1:0]       phase_oh,
    output logic                        busy,
    output logic                        wrap,
    output logic                        done,
    output logic                        o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PH_W-1:0]       r_phase;
    logic [PH_W-1:0]       w_phase_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [CNT_W-1:0]      r_dur [NUM_PHASES];
    logic [CNT_W-1:0]      w_cur_dur;
    logic                  w_latch;
    logic                  w_done_nxt;
    logic                  w_wrap_nxt;
    logic [NUM_PHASES-1:0] w_oh_nxt;

    logic [NUM_PHASES-1:0] r_phase_oh;
    logic                  r_busy;
    logic                  r_wrap;
    logic                  r_done;
    logic                  r_o;

    assign w_cur_dur = r_dur[r_phase];

    // NOTE: every signal assigned here gets its default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_done_nxt  = 1'b0;
        w_oh_nxt    = '0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = '0;
                    w_cnt_nxt   = '0;
                end else if (start) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_phase_nxt = '0;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = '0;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == w_cur_dur) begin
                    w_cnt_nxt = '0;
                    if (r_phase == LAST_PH) begin
                        w_phase_nxt = '0;
                        if (LOOP == 0) begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_phase_nxt = r_phase + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_phase_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_state_nxt == ST_RUN) begin
            w_oh_nxt[w_phase_nxt] = 1'b1;
        end
    end

    // wrap marks the final cycle of the last phase, so it is decoded from the
    // upcoming phase/count; the last phase is never entered straight from a latch.
    assign w_wrap_nxt = (LOOP != 0) && (w_state_nxt == ST_RUN) &&
                        (w_phase_nxt == LAST_PH) && (w_cnt_nxt == r_dur[LAST_PH]);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_phase    <= '0;
            r_cnt      <= '0;
            r_phase_oh <= '0;
            r_busy     <= 1'b0;
            r_wrap     <= 1'b0;
            r_done     <= 1'b0;
            r_o        <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_cnt      <= w_cnt_nxt;
            r_phase_oh <= w_oh_nxt;
            r_busy     <= (w_state_nxt == ST_RUN);
            r_wrap     <= w_wrap_nxt;
            r_done     <= w_done_nxt;
            r_o        <= (w_state_nxt == ST_DONE);
        end
    end

    // NOTE: the duration bank has no reset; it is only read in RUN, and RUN
    // is entered exclusively through a latch that loads every entry.
    always_ff @(posedge clk) begin
        if (w_latch) begin
            for (int k = 0; k < NUM_PHASES; k++) begin
                r_dur[k] <= dur[k*CNT_W +: CNT_W];
            end
        end
    end

    assign phase_idx = r_phase;
    assign phase_oh  = r_phase_oh;
    assign busy      = r_busy;
    assign wrap      = r_wrap;
    assign done      = r_done;
    assign o         = r_o;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: a one-shot and a looping instance compared each
// cycle against an elapsed-time model, plus directed timing checks.
module tb_phase_sequencer;

    localparam int NP   = 4;
    localparam int CW   = 5;
    localparam int PW   = 2;
    localparam int DW   = NP * CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_start, s_abort, l_start, l_abort;
    logic [DW-1:0] s_dur, l_dur;

    logic [PW-1:0] o1_idx, o2_idx;
    logic [NP-1:0] o1_oh, o2_oh;
    logic          o1_busy, o1_wrap, o1_done, o1_o;
    logic          o2_busy, o2_wrap, o2_done, o2_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: elapsed cycles into the current run (-1 when not running).
    int t_run [2];
    bit m_o   [2];
    bit m_done[2];
    int m_d   [2][NP];

    always #5 clk = ~clk;

    phase_sequencer #(.NUM_PHASES(NP), .CNT_W(CW), .LOOP(0)) u_one (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .dur(s_dur),
        .phase_idx(o1_idx), .phase_oh(o1_oh), .busy(o1_busy), .wrap(o1_wrap),
        .done(o1_done), .o(o1_o)
    );

    phase_sequencer #(.NUM_PHASES(NP), .CNT_W(CW), .LOOP(1)) u_loop (
        .clk(clk), .rst(rst), .start(l_start), .abort(l_abort), .dur(l_dur),
        .phase_idx(o2_idx), .phase_oh(o2_oh), .busy(o2_busy), .wrap(o2_wrap),
        .done(o2_done), .o(o2_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] pack_dur(input int d3, input int d2, input int d1, input int d0);
        logic [CW-1:0] f3, f2, f1, f0;
        f3 = CW'(d3);
        f2 = CW'(d2);
        f1 = CW'(d1);
        f0 = CW'(d0);
        return {f3, f2, f1, f0};
    endfunction

    function automatic int period(input int u);
        int p = 0;
        for (int k = 0; k < NP; k++) p += m_d[u][k] + 1;
        return p;
    endfunction

    function automatic int phase_of(input int u, input int t);
        int acc = 0;
        for (int k = 0; k < NP; k++) begin
            acc += m_d[u][k] + 1;
            if (t < acc) return k;
        end
        return NP - 1;
    endfunction

    task automatic model_step(input int u, input bit r, input bit st, input bit ab,
                              input logic [DW-1:0] d, input bit lp);
        m_done[u] = 1'b0;
        if (r) begin
            t_run[u] = -1;
            m_o[u]   = 1'b0;
        end else if (t_run[u] >= 0) begin
            if (ab) begin
                t_run[u] = -1;
            end else begin
                t_run[u]++;
                if (t_run[u] == period(u)) begin
                    if (lp) begin
                        t_run[u] = 0;
                    end else begin
                        t_run[u]  = -1;
                        m_o[u]    = 1'b1;
                        m_done[u] = 1'b1;
                    end
                end
            end
        end else if (ab) begin
            m_o[u] = 1'b0;
        end else if (st) begin
            for (int k = 0; k < NP; k++) m_d[u][k] = int'(d[k*CW +: CW]);
            t_run[u] = 0;
            m_o[u]   = 1'b0;
        end
    endtask

    function automatic logic [9:0] exp_vec(input int u, input bit lp);
        int            ph = 0;
        logic [1:0]    ph2;
        logic [NP-1:0] oh = '0;
        bit            b  = (t_run[u] >= 0);
        bit            w  = 1'b0;
        if (b) begin
            ph     = phase_of(u, t_run[u]);
            oh[ph] = 1'b1;
            w      = lp && (t_run[u] == period(u) - 1);
        end
        ph2 = ph[1:0];
        return {ph2, oh, b, w, m_done[u], m_o[u]};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(0, rst, s_start, s_abort, s_dur, 1'b0);
        model_step(1, rst, l_start, l_abort, l_dur, 1'b1);
        cyc++;
        #1;
        check("one_outputs", 32'({o1_idx, o1_oh, o1_busy, o1_wrap, o1_done, o1_o}), 32'(exp_vec(0, 1'b0)));
        check("loop_outputs", 32'({o2_idx, o2_oh, o2_busy, o2_wrap, o2_done, o2_o}), 32'(exp_vec(1, 1'b1)));
    endtask

    // Called one cycle after the start edge; returns the cycle number at which done shows.
    task automatic wait_done(output int n);
        n = 1;
        while (!o1_done && n < 80) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int wq[$];

        for (int u = 0; u < 2; u++) begin
            t_run[u]  = -1;
            m_o[u]    = 1'b0;
            m_done[u] = 1'b0;
            for (int k = 0; k < NP; k++) m_d[u][k] = 0;
        end
        rst = 1'b1;
        s_start = 1'b0; s_abort = 1'b0; s_dur = '0;
        l_start = 1'b0; l_abort = 1'b0; l_dur = '0;
        tick();
        tick();
        check("reset_state", 32'({o1_idx, o1_oh, o1_busy, o1_wrap, o1_done, o1_o}), 32'd0);
        rst = 1'b0;

        // One-shot timing: phases 10,10,16,1 cycles -> done at cycle 38.
        s_dur = pack_dur(0, 15, 9, 9);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        wait_done(n);
        check("oneshot_done_cycle", n, 38);
        tick();
        check("o_sticky", o1_o, 1'b1);
        check("done_one_cycle", o1_done, 1'b0);

        // Start held high through the run, dur disturbed at cycle 5: no effect.
        s_dur = pack_dur(0, 15, 9, 9);
        s_start = 1'b1;
        tick();
        n = 1;
        while (!o1_done && n < 80) begin
            if (n == 5) s_dur = pack_dur(3, 1, 30, 2);
            tick();
            n++;
        end
        check("start_held_done_cycle", n, 38);
        s_start = 1'b0;
        s_abort = 1'b1;
        tick();
        s_abort = 1'b0;
        tick();

        // Abort at cycle 15 -> idle at 16, restart at 20 -> phase 0 at 21.
        s_dur = pack_dur(0, 15, 9, 9);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        repeat (14) tick();
        s_abort = 1'b1;
        tick();
        s_abort = 1'b0;
        check("abort_busy", o1_busy, 1'b0);
        check("abort_oh", 32'(o1_oh), 32'd0);
        repeat (4) tick();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("restart_oh", 32'(o1_oh), 32'd1);
        wait_done(n);
        check("restart_done_cycle", n, 38);

        // Loop mode: 3 cycles per phase, wraps at 12, 24, 36, never done.
        l_dur = pack_dur(2, 2, 2, 2);
        l_start = 1'b1;
        tick();
        l_start = 1'b0;
        wq.delete();
        for (int i = 1; i <= 40; i++) begin
            if (o2_wrap) wq.push_back(i);
            if (i < 40) tick();
        end
        check("wrap_count", wq.size(), 3);
        if (wq.size() == 3) begin
            check("wrap_first", wq[0], 12);
            check("wrap_second", wq[1], 24);
            check("wrap_third", wq[2], 36);
        end
        check("loop_busy", o2_busy, 1'b1);
        l_abort = 1'b1;
        tick();
        l_abort = 1'b0;

        // Reset at cycle 25 of a one-shot run; start ignored while rst is high.
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        repeat (24) tick();
        rst = 1'b1;
        s_start = 1'b1;
        tick();
        check("rst_midrun", 32'({o1_idx, o1_oh, o1_busy, o1_wrap, o1_done, o1_o}), 32'd0);
        tick();
        check("rst_start_ignored", o1_busy, 1'b0);
        rst = 1'b0;
        s_start = 1'b0;
        tick();

        // DONE -> start relatches new durations and clears o.
        s_dur = pack_dur(1, 2, 3, 4);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        wait_done(n);
        check("short_done_cycle", n, 15);
        tick();
        tick();
        check("o_held", o1_o, 1'b1);
        s_dur = pack_dur(0, 0, 0, 5);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("relatch_o_clear", o1_o, 1'b0);
        check("relatch_busy", o1_busy, 1'b1);
        wait_done(n);
        check("relatch_done_cycle", n, 10);
        s_abort = 1'b1;
        tick();
        check("abort_in_done_o", o1_o, 1'b0);
        s_start = 1'b1;
        tick();
        check("abort_beats_start", o1_busy, 1'b0);
        s_start = 1'b0;
        s_abort = 1'b0;
        tick();

        // Randomised traffic on both instances.
        for (int i = 0; i < 500; i++) begin
            s_start = ($urandom_range(0, 3) == 0);
            s_abort = ($urandom_range(0, 31) == 0);
            l_start = ($urandom_range(0, 3) == 0);
            l_abort = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0)
                s_dur = pack_dur($urandom_range(0, 6), $urandom_range(0, 6),
                                 $urandom_range(0, 6), $urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0)
                l_dur = pack_dur($urandom_range(0, 31), $urandom_range(0, 4),
                                 $urandom_range(0, 4), $urandom_range(0, 4));
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;
        s_start = 1'b0; s_abort = 1'b0; l_start = 1'b0; l_abort = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
